xbus_arbiter: RTL and testbench

- Shares one MC9999 XBus reader port between NUM_WRITERS MC9999 XBus writer ports.
- Writers present data with the write strobe. The arbiter grants one writer per big-clock step using round-robin order, latches that writer's word and offers it to the reader. When the reader takes the word, the arbiter returns a one-cycle read acknowledge to the winning writer.
- Sits between chip instances in a design-level wrapper, in place of a point-to-point x0/x1 wire bundle.

---
 rtl/xbus_pkg.sv | 24 ++
 rtl/xbus_arbiter_if.sv | 25 ++
 rtl/rr_picker.sv | 31 +++
 rtl/xbus_arbiter.sv | 137 +++++++++++++
 tb/tb_xbus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_pkg.sv
// Shared XBus definitions: word width, signed word type, arbiter state
// encoding and a saturating counter helper.
package xbus_pkg;

  localparam int XBUS_W = 11;

  typedef logic signed [XBUS_W-1:0] xbus_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/xbus_arbiter_if.sv
// Writer/reader XBus bundle seen by the arbiter. The master modport is the
// chip side (writers and reader), the slave modport is the arbiter.
interface xbus_arbiter_if #(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_W      = xbus_pkg::XBUS_W
);

  logic [NUM_WRITERS*DATA_W-1:0] wr_data;
  logic [NUM_WRITERS-1:0]        wr_req;
  logic [NUM_WRITERS-1:0]        wr_ack;
  logic                          rd_req;
  logic                          rd_valid;
  logic [DATA_W-1:0]             rd_data;

  modport master (
    output wr_data, wr_req, rd_req,
    input  wr_ack, rd_valid, rd_data
  );

  modport slave (
    input  wr_data, wr_req, rd_req,
    output wr_ack, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin search: first requester after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+N so the last served writer is considered last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// Shares one XBus reader between NUM_WRITERS writers, one grant per
// big-clock step in round-robin order. Optional statistics counters are
// enabled with the XBUS_ARB_STATS_EN macro.
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_W      = XBUS_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              posedge_big_clk,
  xbus_arbiter_if.slave     bus
`ifdef XBUS_ARB_STATS_EN
  ,
  output logic [15:0]       xfer_count,
  output logic [15:0]       contend_count
`endif
);

  localparam int IDX_W = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;

  arb_state_t             state_r, state_nx;
  logic [IDX_W-1:0]       ptr_r, grant_r, pick_idx;
  logic                   pick_found;
  logic                   grant_go, xfer_go;
  logic [DATA_W-1:0]      pick_word;
  logic                   rd_valid_nx;
  logic [NUM_WRITERS-1:0] wr_ack_nx;
  logic                   rd_valid_r;
  logic [DATA_W-1:0]      rd_data_r;
  logic [NUM_WRITERS-1:0] wr_ack_r;

  rr_picker #(.N(NUM_WRITERS), .IDX_W(IDX_W)) u_picker (
    .req   (bus.wr_req),
    .ptr   (ptr_r),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Mux out the word of the writer the picker selected.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_word = bus.wr_data[i*DATA_W +: DATA_W];
      end else begin
        pick_word = pick_word;
      end
    end
  end

  // Next state: grant on a big-clock pulse, abort beats read, ACK lasts one cycle.
  always_comb begin
    state_nx = state_r;
    grant_go = 1'b0;
    xfer_go  = 1'b0;
    case (state_r)
      IDLE: begin
        if (posedge_big_clk && pick_found) begin
          state_nx = OFFER;
          grant_go = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      OFFER: begin
        if (!bus.wr_req[grant_r]) begin
          state_nx = IDLE;
        end else if (bus.rd_req) begin
          state_nx = ACK;
          xfer_go  = 1'b1;
        end else begin
          state_nx = OFFER;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output values for the coming state; registered below.
  always_comb begin
    rd_valid_nx = (state_nx == OFFER);
    wr_ack_nx   = '0;
    if (state_nx == ACK) begin
      wr_ack_nx[grant_r] = 1'b1;
    end else begin
      wr_ack_nx = '0;
    end
  end

  // State, round-robin pointer, grant/hold registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ptr_r      <= IDX_W'(NUM_WRITERS - 1);
      grant_r    <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      wr_ack_r   <= '0;
    end else begin
      state_r    <= state_nx;
      rd_valid_r <= rd_valid_nx;
      wr_ack_r   <= wr_ack_nx;
      if (grant_go) begin
        grant_r   <= pick_idx;
        rd_data_r <= pick_word;
      end
      if (xfer_go) begin
        ptr_r <= grant_r;
      end
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.wr_ack   = wr_ack_r;

`ifdef XBUS_ARB_STATS_EN
  // Saturating counts of completed transfers and contended grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count    <= 16'd0;
      contend_count <= 16'd0;
    end else begin
      if (xfer_go) begin
        xfer_count <= sat_inc16(xfer_count);
      end
      if (grant_go && ($countones(bus.wr_req) > 1)) begin
        contend_count <= sat_inc16(contend_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: directed scenarios plus random
// traffic compared against a transaction-level model of the arbitration rules.
module tb_xbus_arbiter;
  import xbus_pkg::*;

  localparam int N = 4;
  localparam int W = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic posedge_big_clk = 1'b0;
`ifdef XBUS_ARB_STATS_EN
  logic [15:0] xfer_count;
  logic [15:0] contend_count;
`endif

  xbus_arbiter_if #(.NUM_WRITERS(N), .DATA_W(W)) bus ();

  xbus_arbiter #(.NUM_WRITERS(N), .DATA_W(W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .posedge_big_clk (posedge_big_clk),
    .bus             (bus)
`ifdef XBUS_ARB_STATS_EN
    ,
    .xfer_count      (xfer_count),
    .contend_count   (contend_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the current offer (if any), a pending acknowledge,
  // and who was served last.
  bit          m_offer;
  int          m_who;
  logic [W-1:0] m_word;
  int          m_ack_who;
  int          m_last;
  int          m_xfers;
  int          m_contend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i);
    logic [N*W-1:0] d;
    d = bus.wr_data;
    return d[i*W +: W];
  endfunction

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.wr_data[i*W +: W] = v;
  endtask

  task automatic model_reset();
    m_offer   = 1'b0;
    m_who     = 0;
    m_word    = '0;
    m_ack_who = -1;
    m_last    = N - 1;
    m_xfers   = 0;
    m_contend = 0;
  endtask

  // Apply the arbitration rules to the inputs sampled at this edge.
  task automatic model_edge();
    int w;
    if (m_ack_who >= 0) begin
      m_ack_who = -1;
    end else if (m_offer) begin
      if (!bus.wr_req[m_who]) begin
        m_offer = 1'b0;
      end else if (bus.rd_req) begin
        m_offer   = 1'b0;
        m_ack_who = m_who;
        m_last    = m_who;
        if (m_xfers < 65535) m_xfers++;
      end
    end else if (posedge_big_clk && bus.wr_req != '0) begin
      for (int k = 1; k <= N; k++) begin
        w = (m_last + k) % N;
        if (!m_offer && bus.wr_req[w]) begin
          m_offer = 1'b1;
          m_who   = w;
          m_word  = word_of(w);
        end
      end
      if ($countones(bus.wr_req) > 1 && m_contend < 65535) m_contend++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] exp_ack;
    exp_ack = (m_ack_who >= 0) ? N'(1 << m_ack_who) : '0;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'(m_offer));
    check({tag, "_ack"}, 32'(bus.wr_ack), 32'(exp_ack));
    if (m_offer) check({tag, "_data"}, 32'(bus.rd_data), 32'(m_word));
`ifdef XBUS_ARB_STATS_EN
    check({tag, "_xfer_cnt"}, 32'(xfer_count), 32'(m_xfers));
    check({tag, "_contend_cnt"}, 32'(contend_count), 32'(m_contend));
`endif
  endtask

  // One clock: edge, model update, then sample outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    posedge_big_clk = 1'b0;
    bus.wr_req      = '0;
    bus.rd_req      = 1'b0;
    bus.wr_data     = '0;
    reset_n         = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    compare_all("reset");
  endtask

  initial begin
    logic [N-1:0] flip;
    bus.wr_req  = '0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    model_reset();

    // Reset state
    do_reset();
    check("reset_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_data", 32'(bus.rd_data), 32'd0);
    check("reset_ack", 32'(bus.wr_ack), 32'd0);

    // 1. Single writer
    bus.wr_req = 4'b0100;
    set_word(2, 11'sd123);
    posedge_big_clk = 1'b1;
    step("t1_grant");
    posedge_big_clk = 1'b0;
    check("t1_valid_rise", 32'(bus.rd_valid), 32'd1);
    check("t1_data", 32'(bus.rd_data), 32'd123);
    step("t1_wait");
    check("t1_no_ack_yet", 32'(bus.wr_ack), 32'd0);
    bus.rd_req = 1'b1;
    step("t1_read");
    check("t1_ack", 32'(bus.wr_ack), 32'b0100);
    check("t1_valid_drop", 32'(bus.rd_valid), 32'd0);
    step("t1_after");
    check("t1_ack_one_cycle", 32'(bus.wr_ack), 32'd0);
    bus.wr_req = '0;
    bus.rd_req = 1'b0;
    step("t1_idle");

    // 2. Round-robin fairness
    do_reset();
    bus.wr_req = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, W'(i + 1));
    bus.rd_req = 1'b1;
    for (int s = 0; s < 8; s++) begin
      posedge_big_clk = 1'b1;
      step("t2_grant");
      posedge_big_clk = 1'b0;
      check("t2_word", 32'(bus.rd_data), 32'((s % N) + 1));
      step("t2_xfer");
      check("t2_ack", 32'(bus.wr_ack), 32'(1 << (s % N)));
      step("t2_idle");
      check("t2_one_per_step", 32'(bus.rd_valid), 32'd0);
    end
    bus.rd_req = 1'b0;
    bus.wr_req = '0;

    // 3. Writer withdraw
    do_reset();
    bus.wr_req = 4'b0010;
    set_word(1, 11'sd77);
    set_word(3, 11'sd33);
    posedge_big_clk = 1'b1;
    step("t3_grant");
    posedge_big_clk = 1'b0;
    check("t3_valid", 32'(bus.rd_valid), 32'd1);
    bus.wr_req = 4'b0000;
    step("t3_withdraw");
    check("t3_valid_drop", 32'(bus.rd_valid), 32'd0);
    check("t3_no_ack", 32'(bus.wr_ack), 32'd0);
    bus.wr_req = 4'b1010;
    posedge_big_clk = 1'b1;
    step("t3_regrant");
    posedge_big_clk = 1'b0;
    check("t3_same_writer", 32'(bus.rd_data), 32'd77);
    bus.rd_req = 1'b1;
    step("t3_read");
    check("t3_ack", 32'(bus.wr_ack), 32'b0010);
    bus.rd_req = 1'b0;
    bus.wr_req = '0;
    step("t3_idle");

    // 4. Abort vs read collision
    do_reset();
    bus.wr_req = 4'b0001;
    set_word(0, 11'sd5);
    posedge_big_clk = 1'b1;
    step("t4_grant");
    posedge_big_clk = 1'b0;
    bus.wr_req = 4'b0000;
    bus.rd_req = 1'b1;
    step("t4_collide");
    check("t4_no_ack", 32'(bus.wr_ack), 32'd0);
    check("t4_idle", 32'(bus.rd_valid), 32'd0);
    step("t4_after");
    check("t4_still_no_ack", 32'(bus.wr_ack), 32'd0);
    bus.rd_req = 1'b0;

    // 5. Reset mid-OFFER
    do_reset();
    bus.wr_req = 4'b0001;
    set_word(0, -11'sd5);
    posedge_big_clk = 1'b1;
    step("t5_grant");
    posedge_big_clk = 1'b0;
    check("t5_data_neg", 32'(bus.rd_data), 32'h7FB);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t5_async_valid", 32'(bus.rd_valid), 32'd0);
    check("t5_async_data", 32'(bus.rd_data), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.wr_req = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, W'(10 * (i + 1)));
    posedge_big_clk = 1'b1;
    step("t5_regrant");
    posedge_big_clk = 1'b0;
    check("t5_writer0_first", 32'(bus.rd_data), 32'd10);
    bus.wr_req = '0;
    step("t5_idle");

    // 6. Reader idle for several big-clock steps
    do_reset();
    bus.wr_req = 4'b1000;
    set_word(3, 11'sd999);
    posedge_big_clk = 1'b1;
    step("t6_grant");
    for (int s = 0; s < 5; s++) begin
      posedge_big_clk = 1'b1;
      bus.wr_data = (N*W)'({$urandom, $urandom});
      step("t6_hold");
      posedge_big_clk = 1'b0;
      step("t6_hold");
      step("t6_hold");
      check("t6_valid", 32'(bus.rd_valid), 32'd1);
      check("t6_data", 32'(bus.rd_data), 32'd999);
    end
    bus.rd_req = 1'b1;
    step("t6_read");
    check("t6_ack", 32'(bus.wr_ack), 32'b1000);
    bus.rd_req = 1'b0;
    bus.wr_req = '0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      posedge_big_clk = ($urandom_range(0, 2) == 0);
      flip = N'($urandom) & N'($urandom) & N'($urandom);
      bus.wr_req = bus.wr_req ^ flip;
      bus.wr_data = (N*W)'({$urandom, $urandom});
      bus.rd_req = ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
